matriz_varredura_coluna: RTL and testbench

- Time-multiplexed column scan driver for the 5x7 LED matrix; the consumer side of the 4-bit column coordinate (cdc) produced by the column-coordinate encoder.
- Accepts row patterns addressed by column coordinate into a shadow frame buffer, swaps to the display buffer on a frame boundary, then cycles through columns.
- For each column it drives an active-low one-hot column select and the matching row pattern, with an anti-ghosting blank interval at the start of each slot.

---
 rtl/matriz_varredura_coluna_pkg.sv | 11 +
 rtl/matriz_dec_coluna.sv | 10 +
 rtl/matriz_varredura_coluna.sv | 74 +++++++
 tb/tb_matriz_varredura_coluna.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/matriz_varredura_coluna_pkg.sv
// matriz_varredura_coluna_pkg: shared widths, scan states and coordinate check for the LED matrix column path
package matriz_varredura_coluna_pkg;
  localparam int N_COLS = 5;
  localparam int N_ROWS = 7;
  localparam int COORD_W = 4;
  localparam logic [N_COLS-1:0] COL_BLANK = '1;
  typedef enum logic {BLANK, DRIVE} scan_state_t;
  function automatic logic coord_valid(input logic [COORD_W-1:0] cdc);
    return cdc < COORD_W'(N_COLS);
  endfunction
endpackage

// File: rtl/matriz_dec_coluna.sv
// matriz_dec_coluna: coordinate plus enable to active-low one-hot column select
module matriz_dec_coluna
  import matriz_varredura_coluna_pkg::*;
(
  input  logic               en,
  input  logic [COORD_W-1:0] cdc,
  output logic [N_COLS-1:0]  sel
);
  always_comb sel = (en && coord_valid(cdc)) ? ~(N_COLS'(1) << cdc) : COL_BLANK;
endmodule

// File: rtl/matriz_varredura_coluna.sv
// matriz_varredura_coluna: double-buffered 5x7 column scan driver with anti-ghosting blank
module matriz_varredura_coluna
  import matriz_varredura_coluna_pkg::*;
#(
  parameter int SLOT_CYC = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_cdc,
  input  logic [N_ROWS-1:0]  wr_row,
  input  logic               commit,
  output logic               wr_ready,
  output logic [N_COLS-1:0]  col_sel,
  output logic [N_ROWS-1:0]  row_out,
  output logic [COORD_W-1:0] scan_cdc,
  output logic               frame_done,
  output logic               err_coord
);
  localparam int SW = $clog2(SLOT_CYC);
  localparam int IW = $clog2(N_COLS);
  scan_state_t state, state_nxt;
  logic [SW-1:0] slot_cnt, slot_nxt;
  logic [COORD_W-1:0] scan_nxt;
  logic [N_COLS-1:0] sel_nxt;
  logic pending, pending_nxt, slot_end, frame_end, frame_nxt, wr_ok, swap, drive_nxt;
  logic [N_ROWS-1:0] shadow_buf [N_COLS];
  logic [N_ROWS-1:0] disp_buf [N_COLS];
  always_comb begin
    slot_end = slot_cnt == SW'(SLOT_CYC - 1);
    frame_end = slot_end && scan_cdc == COORD_W'(N_COLS - 1);
    slot_nxt = slot_end ? '0 : slot_cnt + 1'b1;
    scan_nxt = !slot_end ? scan_cdc : frame_end ? '0 : scan_cdc + 1'b1;
    state_nxt = (state == BLANK && slot_nxt == SW'(BLANK_CYC)) ? DRIVE :
                (state == DRIVE && slot_end) ? BLANK : state;
    drive_nxt = state_nxt == DRIVE;
    frame_nxt = slot_nxt == SW'(SLOT_CYC - 1) && scan_nxt == COORD_W'(N_COLS - 1);
    wr_ok = wr_en && wr_ready;
    swap = frame_end && pending;
    pending_nxt = swap ? 1'b0 : (commit && wr_ready) ? 1'b1 : pending;
  end
  matriz_dec_coluna u_dec (.en(drive_nxt), .cdc(scan_nxt), .sel(sel_nxt));
  // outputs are registered from next-state values so they switch on the state-change edge
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      scan_cdc <= '0;
      state <= BLANK;
      pending <= 1'b0;
      wr_ready <= 1'b1;
      col_sel <= COL_BLANK;
      row_out <= '0;
      frame_done <= 1'b0;
      err_coord <= 1'b0;
      for (int i = 0; i < N_COLS; i++) begin
        shadow_buf[i] <= '0;
        disp_buf[i] <= '0;
      end
    end else begin
      slot_cnt <= slot_nxt;
      scan_cdc <= scan_nxt;
      state <= state_nxt;
      pending <= pending_nxt;
      wr_ready <= !pending_nxt;
      col_sel <= sel_nxt;
      row_out <= drive_nxt ? disp_buf[scan_nxt[IW-1:0]] : '0;
      frame_done <= frame_nxt;
      err_coord <= wr_ok && !coord_valid(wr_cdc);
      if (wr_ok && coord_valid(wr_cdc)) shadow_buf[wr_cdc[IW-1:0]] <= wr_row;
      if (swap) disp_buf <= shadow_buf;
    end
  end
endmodule

// File: tb/tb_matriz_varredura_coluna.sv
// tb_matriz_varredura_coluna: scoreboard bench for the column scan driver
module tb_matriz_varredura_coluna;
  logic clk = 0, rst = 1, wr_en = 0, commit = 0;
  logic [3:0] wr_cdc = 0;
  logic [6:0] wr_row = 0;
  logic wr_ready, frame_done, err_coord;
  logic [4:0] col_sel;
  logic [6:0] row_out;
  logic [3:0] scan_cdc;
  int n_chk = 0, n_fail = 0, m_t = 0;
  logic m_pending = 0, m_err = 0;
  logic [6:0] m_shadow [5];
  logic [6:0] m_disp [5];
  logic [18:0] sb [$];
  logic [18:0] got, e;
  matriz_varredura_coluna #(.SLOT_CYC(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cdc(wr_cdc), .wr_row(wr_row), .commit(commit),
    .wr_ready(wr_ready), .col_sel(col_sel), .row_out(row_out), .scan_cdc(scan_cdc),
    .frame_done(frame_done), .err_coord(err_coord)
  );
  always #5 clk = ~clk;
  task automatic tick();
    logic rdy;
    int s, c;
    logic [2:0] ci;
    rdy = !m_pending;
    if (rst) begin
      m_t = 0;
      m_pending = 0;
      m_err = 0;
      for (int i = 0; i < 5; i++) begin
        m_shadow[i] = 0;
        m_disp[i] = 0;
      end
    end else begin
      m_err = wr_en && rdy && wr_cdc >= 5;
      if (m_t % 40 == 39 && m_pending) begin
        m_disp = m_shadow;
        m_pending = 0;
      end else if (commit && rdy) m_pending = 1;
      if (wr_en && rdy && wr_cdc < 5) m_shadow[wr_cdc[2:0]] = wr_row;
      m_t++;
    end
    s = m_t % 8;
    c = (m_t / 8) % 5;
    ci = c[2:0];
    sb.push_back({s < 2 ? 5'h1f : ~(5'b1 << c), s < 2 ? 7'h0 : m_disp[ci], 4'(c),
                  m_t % 40 == 39, !m_pending, m_err});
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      got = {col_sel, row_out, scan_cdc, frame_done, wr_ready, err_coord};
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL reset got=%h exp=%h", got, e); end
    end
    n_chk++;
    if (col_sel !== 5'h1f || row_out !== 0 || scan_cdc !== 0 || wr_ready !== 1)
      begin n_fail++; $display("FAIL reset_vals got=%b/%b/%0d/%b exp=11111/0/0/1", col_sel, row_out, scan_cdc, wr_ready); end
  endtask
  task automatic test_scan();
    logic [4:0] tbl [6];
    int pulses = 0;
    tbl = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11110};
    for (int i = 0; i < 80; i++) begin
      tick();
      e = sb.pop_front();
      got = {col_sel, row_out, scan_cdc, frame_done, wr_ready, err_coord};
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL scan t=%0d got=%h exp=%h", m_t, got, e); end
      pulses += frame_done ? 1 : 0;
      if (m_t % 8 == 4 && m_t < 48) begin
        n_chk++;
        if (col_sel !== tbl[m_t / 8]) begin n_fail++; $display("FAIL col_order t=%0d got=%b exp=%b", m_t, col_sel, tbl[m_t / 8]); end
      end
    end
    n_chk++;
    if (pulses != 2) begin n_fail++; $display("FAIL frame_done_count got=%0d exp=2", pulses); end
  endtask
  task automatic test_write_commit();
    for (int i = 0; i < 80; i++) begin
      wr_en = i < 2;
      wr_cdc = i == 0 ? 4'd2 : 4'd0;
      wr_row = i == 0 ? 7'b1010101 : 7'b0000001;
      commit = i == 10;
      tick();
      e = sb.pop_front();
      got = {col_sel, row_out, scan_cdc, frame_done, wr_ready, err_coord};
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL wr_commit t=%0d got=%h exp=%h", m_t, got, e); end
      if (m_t >= 91 && m_t < 120) begin
        n_chk++;
        if (wr_ready !== 0) begin n_fail++; $display("FAIL wr_ready_busy t=%0d got=%b exp=0", m_t, wr_ready); end
      end
      if (m_t < 120 && col_sel !== 5'h1f) begin
        n_chk++;
        if (row_out !== 0) begin n_fail++; $display("FAIL old_frame t=%0d got=%b exp=0", m_t, row_out); end
      end
      if (m_t >= 120 && (col_sel === 5'b11011 || col_sel === 5'b11110)) begin
        n_chk++;
        if (row_out !== (col_sel[2] ? 7'b0000001 : 7'b1010101))
          begin n_fail++; $display("FAIL new_frame t=%0d col=%b got=%b", m_t, col_sel, row_out); end
      end
    end
    wr_en = 0;
    commit = 0;
  endtask
  task automatic test_same_cycle();
    for (int i = 0; i < 80; i++) begin
      wr_en = i == 0;
      commit = i == 0;
      wr_cdc = 4'd4;
      wr_row = 7'h7f;
      tick();
      e = sb.pop_front();
      got = {col_sel, row_out, scan_cdc, frame_done, wr_ready, err_coord};
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL same_cycle t=%0d got=%h exp=%h", m_t, got, e); end
      if (col_sel === 5'b01111) begin
        n_chk++;
        if (row_out !== (m_t >= 200 ? 7'h7f : 7'h0)) begin n_fail++; $display("FAIL col4 t=%0d got=%b", m_t, row_out); end
      end
      if (m_t >= 200 && col_sel === 5'b11011) begin
        n_chk++;
        if (row_out !== 7'b1010101) begin n_fail++; $display("FAIL shadow_kept t=%0d got=%b exp=1010101", m_t, row_out); end
      end
    end
    wr_en = 0;
    commit = 0;
  endtask
  task automatic test_out_of_range();
    int errs = 0;
    for (int i = 0; i < 80; i++) begin
      wr_en = i == 0 || i == 3;
      wr_cdc = i == 0 ? 4'd5 : 4'd15;
      wr_row = 7'h7f;
      commit = i == 6;
      tick();
      e = sb.pop_front();
      got = {col_sel, row_out, scan_cdc, frame_done, wr_ready, err_coord};
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL oor t=%0d got=%h exp=%h", m_t, got, e); end
      errs += err_coord ? 1 : 0;
      if (m_t >= 280 && (col_sel === 5'b11101 || col_sel === 5'b10111)) begin
        n_chk++;
        if (row_out !== 0) begin n_fail++; $display("FAIL oor_nowrite t=%0d got=%b exp=0", m_t, row_out); end
      end
    end
    n_chk++;
    if (errs != 2) begin n_fail++; $display("FAIL err_count got=%0d exp=2", errs); end
    wr_en = 0;
    commit = 0;
  endtask
  task automatic test_busy();
    int errs = 0;
    for (int i = 0; i < 80; i++) begin
      commit = i == 0 || i == 4;
      wr_en = i == 2 || i == 5;
      wr_cdc = i == 2 ? 4'd1 : 4'd6;
      wr_row = 7'h7f;
      tick();
      e = sb.pop_front();
      got = {col_sel, row_out, scan_cdc, frame_done, wr_ready, err_coord};
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL busy t=%0d got=%h exp=%h", m_t, got, e); end
      errs += err_coord ? 1 : 0;
      if (m_t >= 360) begin
        n_chk++;
        if (wr_ready !== 1) begin n_fail++; $display("FAIL one_swap t=%0d wr_ready got=%b exp=1", m_t, wr_ready); end
      end
      if (m_t >= 360 && col_sel === 5'b11101) begin
        n_chk++;
        if (row_out !== 0) begin n_fail++; $display("FAIL busy_write t=%0d got=%b exp=0", m_t, row_out); end
      end
    end
    n_chk++;
    if (errs != 0) begin n_fail++; $display("FAIL busy_err got=%0d exp=0", errs); end
    wr_en = 0;
    commit = 0;
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 90; i++) begin
      commit = i == 0 || i == 10;
      rst = i == 3;
      tick();
      e = sb.pop_front();
      got = {col_sel, row_out, scan_cdc, frame_done, wr_ready, err_coord};
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL reset_mid i=%0d got=%h exp=%h", i, got, e); end
      if (i == 3) begin
        n_chk++;
        if (got !== 19'b11111_0000000_0000_0_1_0) begin n_fail++; $display("FAIL reset_mid_vals got=%b exp=1111100000000000010", got); end
      end
      if (i > 3) begin
        n_chk++;
        if (row_out !== 0) begin n_fail++; $display("FAIL cleared i=%0d got=%b exp=0", i, row_out); end
      end
    end
    rst = 0;
    commit = 0;
  endtask
  initial begin
    test_reset();
    test_scan();
    test_write_commit();
    test_same_cycle();
    test_out_of_range();
    test_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
